// File: rtl/pc_controller.sv
// -----------------------------------------------------------------------------
// pc_controller
//
// Next-PC sequencer. It reads back the current PC and drives the program
// counter's new value and write enable. It runs a request/acknowledge fetch
// handshake with instruction memory and picks the sequential, branch, jump or
// jump-register target. A redirect that arrives while a fetch is still
// outstanding is parked in pending_target until that fetch completes.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   pc            current PC, read back from the programCounter register
//   fetch_req     instruction-memory request, held until fetch_ack
//   fetch_ack     instruction-memory acknowledge (one-cycle pulse)
//   fetch_valid   fetched instruction is accepted this cycle
//   stall         downstream not ready; blocks sequential advance only
//   branch_taken  conditional branch resolved taken
//   branch_imm    signed branch offset in words
//   jump          J/JAL redirect
//   jump_target   J-format 26-bit target field
//   jump_reg      JR redirect
//   reg_target    register value for JR
//   halt          stop fetching
//   new_pc        value presented to programCounter (0 when not writing)
//   pc_write      programCounter write enable
//   flush         one-cycle pulse: discard the in-flight instruction
//   halted        controller is in HALT
// -----------------------------------------------------------------------------
module pc_controller #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc,
   output logic             fetch_req,
   input  logic             fetch_ack,
   output logic             fetch_valid,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [15:0]      branch_imm,
   input  logic             jump,
   input  logic [25:0]      jump_target,
   input  logic             jump_reg,
   input  logic [WIDTH-1:0] reg_target,
   input  logic             halt,
   output logic [WIDTH-1:0] new_pc,
   output logic             pc_write,
   output logic             flush,
   output logic             halted
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DRAIN,
      ST_HALT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_target_q, pending_target_d;

   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] br_pc;
   logic [WIDTH-1:0] j_pc;
   logic [WIDTH-1:0] jr_pc;
   logic [WIDTH-1:0] target;
   logic             redirect;

   // Candidate targets; all additions wrap modulo 2^WIDTH.
   always_comb begin
      seq_pc = pc + WIDTH'(4);
      br_pc  = seq_pc + {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
      j_pc   = {pc[WIDTH-1:WIDTH-4], jump_target, 2'b00};
      // JR targets are forced word-aligned by masking the two low bits.
      jr_pc  = reg_target & ~WIDTH'(3);
   end

   // Redirect priority: jump_reg > jump > branch_taken.
   always_comb begin
      redirect = jump_reg | jump | branch_taken;
      if (jump_reg) begin
         target = jr_pc;
      end else if (jump) begin
         target = j_pc;
      end else begin
         target = br_pc;
      end
   end

   // NOTE: every output and next-state value gets a default before the case,
   // so no path through this block can leave a signal unassigned (no latch).
   always_comb begin
      state_d          = state_q;
      pending_target_d = pending_target_q;
      fetch_req        = 1'b0;
      fetch_valid      = 1'b0;
      pc_write         = 1'b0;
      new_pc           = '0;
      flush            = 1'b0;
      halted           = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            pc_write = 1'b1;
            new_pc   = RESET_VECTOR;
            state_d  = ST_FETCH;
         end

         ST_FETCH: begin
            fetch_req = 1'b1;
            if (redirect) begin
               // Redirect dominates stall and halt.
               flush = 1'b1;
               if (fetch_ack) begin
                  pc_write = 1'b1;
                  new_pc   = target;
               end else begin
                  // Request still outstanding: park the target until it lands.
                  pending_target_d = target;
                  state_d          = ST_DRAIN;
               end
            end else if (fetch_ack) begin
               if (halt) begin
                  fetch_valid = 1'b1;
                  state_d     = ST_HALT;
               end else if (!stall) begin
                  fetch_valid = 1'b1;
                  pc_write    = 1'b1;
                  new_pc      = seq_pc;
               end
               // Stalled ack: PC is unchanged, so the same word is refetched.
            end
         end

         ST_DRAIN: begin
            fetch_req = 1'b1;
            if (redirect) begin
               pending_target_d = target;  // latest redirect wins
            end
            if (fetch_ack) begin
               pc_write = 1'b1;
               new_pc   = redirect ? target : pending_target_q;
               state_d  = ST_FETCH;
            end
         end

         ST_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before this clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_BOOT;
         pending_target_q <= '0;
      end else begin
         state_q          <= state_d;
         pending_target_q <= pending_target_d;
      end
   end

endmodule

// File: tb/tb_pc_controller.sv
// -----------------------------------------------------------------------------
// tb_pc_controller
//
// Directed bench for pc_controller. The stimulus process drives one input
// vector per cycle and queues the hand-computed output vector expected for
// that cycle; an independent monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pc_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        fetch_req;
   logic        fetch_ack;
   logic        fetch_valid;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_target;
   logic        jump_reg;
   logic [31:0] reg_target;
   logic        halt;
   logic [31:0] new_pc;
   logic        pc_write;
   logic        flush;
   logic        halted;

   always #5 clk = ~clk;

   pc_controller #(
      .WIDTH        (32),
      .RESET_VECTOR (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .fetch_req    (fetch_req),
      .fetch_ack    (fetch_ack),
      .fetch_valid  (fetch_valid),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_target  (jump_target),
      .jump_reg     (jump_reg),
      .reg_target   (reg_target),
      .halt         (halt),
      .new_pc       (new_pc),
      .pc_write     (pc_write),
      .flush        (flush),
      .halted       (halted)
   );

   typedef struct packed {
      logic        fetch_req;
      logic        fetch_valid;
      logic        pc_write;
      logic        flush;
      logic        halted;
      logic [31:0] new_pc;
   } outs_t;

   typedef struct packed {
      logic        reset;
      logic [31:0] pc;
      logic        fetch_ack;
      logic        stall;
      logic        branch_taken;
      logic [15:0] branch_imm;
      logic        jump;
      logic [25:0] jump_target;
      logic        jump_reg;
      logic [31:0] reg_target;
      logic        halt;
   } stim_t;

   outs_t exp_q[$];
   string name_q[$];
   int    tests_run    = 0;
   int    tests_failed = 0;

   function automatic outs_t ex(input logic req, input logic fv, input logic pw,
                                input logic fl, input logic ht,
                                input logic [31:0] npc);
      outs_t e;
      e.fetch_req   = req;
      e.fetch_valid = fv;
      e.pc_write    = pw;
      e.flush       = fl;
      e.halted      = ht;
      e.new_pc      = npc;
      return e;
   endfunction

   function automatic stim_t st(input logic [31:0] pc_v, input logic ack);
      stim_t s;
      s           = '0;
      s.pc        = pc_v;
      s.fetch_ack = ack;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      reset        = s.reset;
      pc           = s.pc;
      fetch_ack    = s.fetch_ack;
      stall        = s.stall;
      branch_taken = s.branch_taken;
      branch_imm   = s.branch_imm;
      jump         = s.jump;
      jump_target  = s.jump_target;
      jump_reg     = s.jump_reg;
      reg_target   = s.reg_target;
      halt         = s.halt;
   endtask

   // One cycle: drive just after the rising edge, queue the expectation.
   task automatic step(input string name, input stim_t s, input outs_t e);
      @(posedge clk);
      #1;
      apply(s);
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Monitor: compares the DUT outputs mid-cycle against the queued entry.
   always @(negedge clk) begin
      outs_t act;
      outs_t exp_v;
      string nm;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         act   = {fetch_req, fetch_valid, pc_write, flush, halted, new_pc};
         tests_run++;
         if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got req=%0b valid=%0b pw=%0b flush=%0b halted=%0b new_pc=%h, expected req=%0b valid=%0b pw=%0b flush=%0b halted=%0b new_pc=%h",
                     nm, act.fetch_req, act.fetch_valid, act.pc_write, act.flush,
                     act.halted, act.new_pc, exp_v.fetch_req, exp_v.fetch_valid,
                     exp_v.pc_write, exp_v.flush, exp_v.halted, exp_v.new_pc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      s       = '0;
      s.reset = 1'b1;
      apply(s);
      repeat (2) @(posedge clk);

      // Reset released: BOOT writes the reset vector.
      s = st(32'h0, 1'b0);
      step("boot", s, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));

      // Sequential fetches.
      s = st(32'h0, 1'b1);
      step("seq_0", s, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4));
      s = st(32'h4, 1'b1);
      step("seq_4", s, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8));
      s = st(32'h8, 1'b1);
      step("seq_8", s, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC));
      s = st(32'hC, 1'b0);
      step("fetch_wait", s, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));

      // Backward branch with ack: 0x104 - 8.
      s = st(32'h100, 1'b1);
      s.branch_taken = 1'b1;
      s.branch_imm   = 16'hFFFE;
      step("branch_back", s, ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFC));

      // Forward branch: 0x14 + 12.
      s = st(32'h10, 1'b1);
      s.branch_taken = 1'b1;
      s.branch_imm   = 16'h0003;
      step("branch_fwd", s, ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20));

      // Jump beats branch; upper nibble comes from pc.
      s = st(32'hA000_0010, 1'b1);
      s.jump         = 1'b1;
      s.jump_target  = 26'h3FF_FFFF;
      s.branch_taken = 1'b1;
      s.branch_imm   = 16'h0005;
      step("jump_over_branch", s, ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAFFF_FFFC));

      // All three redirects: jump_reg wins.
      s = st(32'h200, 1'b1);
      s.jump_reg     = 1'b1;
      s.reg_target   = 32'h8000_0000;
      s.jump         = 1'b1;
      s.jump_target  = 26'h000_0001;
      s.branch_taken = 1'b1;
      s.branch_imm   = 16'h0001;
      step("priority_all", s, ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0000));

      // Sequential wrap.
      s = st(32'hFFFF_FFFC, 1'b1);
      step("seq_wrap", s, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0));

      // Redirect before ack -> DRAIN, later JR overwrites, ack commits it.
      s = st(32'h40, 1'b0);
      s.jump        = 1'b1;
      s.jump_target = 26'h000_0010;
      step("redirect_noack", s, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
      s = st(32'h40, 1'b0);
      s.jump_reg   = 1'b1;
      s.reg_target = 32'h0000_1237;
      step("drain_jr_overwrite", s, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
      s = st(32'h40, 1'b1);
      step("drain_ack_pending", s, ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234));

      // Stall blocks the sequential advance, then releases.
      s = st(32'h20, 1'b1);
      s.stall = 1'b1;
      step("stall_ack", s, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
      s = st(32'h20, 1'b1);
      step("unstall_ack", s, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h24));

      // Redirect dominates stall: 0x28 + 4.
      s = st(32'h24, 1'b1);
      s.stall        = 1'b1;
      s.branch_taken = 1'b1;
      s.branch_imm   = 16'h0001;
      step("redirect_over_stall", s, ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2C));

      // DRAIN ack with a fresh redirect uses it directly; halt is ignored.
      s = st(32'h50, 1'b0);
      s.jump        = 1'b1;
      s.jump_target = 26'h000_0020;
      step("drain_enter", s, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
      s = st(32'h50, 1'b1);
      s.halt         = 1'b1;
      s.branch_taken = 1'b1;
      s.branch_imm   = 16'h0000;
      step("drain_ack_redirect", s, ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h54));

      // Halt on ack, then stay halted until reset.
      s = st(32'h30, 1'b1);
      s.halt = 1'b1;
      step("halt_ack", s, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
      s = st(32'h30, 1'b0);
      step("halted_idle", s, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
      s = st(32'h30, 1'b1);
      s.branch_taken = 1'b1;
      s.branch_imm   = 16'h0004;
      step("halted_ignores", s, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
      s = st(32'h30, 1'b0);
      s.reset = 1'b1;
      step("halted_reset_cycle", s, ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
      s = st(32'h30, 1'b0);
      step("reboot", s, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
      s = st(32'h0, 1'b1);
      step("reboot_seq", s, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4));

      // Reset in the middle of DRAIN abandons the outstanding fetch.
      s = st(32'h60, 1'b0);
      s.jump        = 1'b1;
      s.jump_target = 26'h000_0040;
      step("drain_before_reset", s, ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
      s = st(32'h60, 1'b0);
      s.reset = 1'b1;
      step("drain_reset_cycle", s, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
      s = st(32'h60, 1'b1);
      step("boot_after_drain", s, ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
      s = st(32'h0, 1'b1);
      step("seq_after_drain_reset", s, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4));

      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
